fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of TinyCPU, sitting directly upstream of decode and driving the combinational `inst_mem` read port. It holds the program counter (PC) and presents `pc` as the memory address. It captures the returned 16-bit word into an instruction register (IR) with a valid/ready handshake toward decode. It handles branch redirects and stops fetching when it captures a HALT instruction.

## Interface
- `ADDR_W`, 8: PC / instruction-memory address width.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 8'h00: PC value after reset.
- `HALT_OP`, 4'hF: opcode (`instr[15:12]`) that halts fetch.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_addr`  out  ADDR_W  address to `inst_mem`; combinationally equal to `pc`.
- `imem_data`  in  INSTR_W  instruction from `inst_mem`, valid in the same cycle as `imem_addr`.
- `branch_valid`  in  1  redirect request from execute.
- `branch_target`  in  ADDR_W  redirect address; sampled when `branch_valid`=1.
- `ir_valid`  out  1  IR holds an instruction for decode.
- `ir`  out  INSTR_W  fetched instruction.
- `ir_pc`  out  ADDR_W  address the `ir` word was fetched from.
- `ir_ready`  in  1  decode accepts `ir` this cycle.
- `halted`  out  1  fetch is stopped after a HALT instruction.
- `fetch_count`  out  16  number of completed `ir_valid && ir_ready` handshakes; saturates at 16'hFFFF.

## Operation
- **States:** RUN and HALT. Reset enters RUN.
- **Reset values** (while `rst_n`=0 at an edge):
  - `pc`=RESET_PC, `ir`=0, `ir_pc`=0
  - `ir_valid`=0, `halted`=0, `fetch_count`=0
  - therefore `imem_addr`=RESET_PC
- **Load condition:** `load` = RUN && (!`ir_valid` || `ir_ready`) && !`branch_valid`.
- **On `load`:**
  - `ir`<=`imem_data`, `ir_pc`<=`pc`, `ir_valid`<=1.
  - `pc`<=`pc`+1, modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
  - If `imem_data[15:12]`==HALT_OP, the state goes to HALT, `halted`<=1, and `pc` is not incremented (it stays at the HALT address).
- **Stall:** when `ir_valid`=1 and `ir_ready`=0 (no branch), `ir`, `ir_pc`, `ir_valid` and `pc` hold unchanged.
- **Branch** (`branch_valid`=1, any state; highest priority after reset):
  - `pc`<=`branch_target`, `ir_valid`<=0; `ir` and `ir_pc` keep their values.
  - The state goes to RUN and `halted`<=0.
- **HALT state:**
  - No loads.
  - `ir_valid` clears on the cycle that `ir_ready`=1.
  - `halted` stays 1 until a branch or reset.
- **`fetch_count`:** increments on every edge with `ir_valid && ir_ready`. This includes edges where `branch_valid`=1, because the instruction being accepted is the branch itself.
- **Reset mid-stall or mid-halt:** all state returns to the reset values; any pending IR is discarded.

## Timing
- **Fetch latency:** 1 cycle, PC to IR. The first valid IR is presented in the first cycle after `rst_n` deasserts (the word at RESET_PC).
- **Throughput:** 1 instruction/cycle while `ir_ready`=1.
- **Branch penalty:** one bubble.
  - Edge N samples `branch_valid`.
  - In cycle N+1, `ir_valid`=0 and `imem_addr`=target.
  - At edge N+1, `ir` is loaded with `mem[target]`.
- **Handshake:** `ir` and `ir_pc` must stay stable while `ir_valid`=1 and `ir_ready`=0; `ir_ready` may toggle freely.
- **Outputs:** all registered except `imem_addr`, which is combinational from the `pc` register (no input-to-output combinational path).

## Structure
- **Shared package `tinycpu_pkg`:**
  - `ADDR_W`, `INSTR_W`, `OP_HALT` (4'hF)
  - the fetch state enum {RUN, HALT}
  - the opcode field slice (bits 15:12)
- **Sub-module `fetch_pc`:** PC register with reset, load-target and increment-with-wrap, driven by `load`/`branch`/`halt` enables.
- **Instantiation:** `inst_mem` is instantiated alongside the block by the CPU top, not inside it.

## Test plan
- **Reset and sequential fetch:** memory `mem[0..3]`=1122,3344,DEAD,BEEF; `ir_ready`=1; release `rst_n`.
  - Required: IR sequence 1122/0, 3344/1, DEAD/2, BEEF/3 on consecutive cycles.
  - Required: `fetch_count` reaches 4.
- **Stall:** hold `ir_ready`=0 for 3 cycles while IR=DEAD.
  - Required: `ir`=DEAD, `ir_pc`=2 and `imem_addr`=3 stable.
  - Required: on release, BEEF follows in the next cycle.
- **Branch:** `branch_valid`=1, target 8'h02, while IR=3344 and `ir_ready`=1.
  - Required: exactly one cycle of `ir_valid`=0, then IR=DEAD/2.
  - Required: `fetch_count` counts the 3344 handshake.
- **Halt:** `mem[4]`=F000.
  - Required: IR=F000/4 and `halted`=1; `pc` stays 4.
  - Required: after it is accepted, `ir_valid`=0 indefinitely; a branch to 0 resumes with 1122.
- **Wrap:** branch to 8'hFF with `mem[FF]`=ABCD.
  - Required: IR=ABCD/FF, then `mem[0]` (1122) with `ir_pc`=0.
- **Reset mid-operation:** assert `rst_n`=0 during a stall with IR valid.
  - Required: the next cycle shows all outputs at reset values and `imem_addr`=RESET_PC.

Source files
------------

// File: rtl/tinycpu_pkg.sv
// Shared TinyCPU definitions: datapath widths, HALT opcode, opcode field
// position and the fetch-stage state encoding.
package tinycpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_HALT = 4'hF;

    // Opcode field slice within an instruction word
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: reset to RESET_PC, load a branch target, or step by one
// (wrapping naturally at 2^ADDR_W) unless the word just fetched is a HALT.
module fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              branch_i,
    input  logic              halt_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // Branch wins over any load; a HALT fetch parks the PC on its own address
    always_comb begin
        pc_d = pc_q;
        if (branch_i)
            pc_d = target_i;
        else if (load_i && !halt_i)
            pc_d = pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// TinyCPU fetch stage: PC drives inst_mem, the returned word is captured in
// the IR with a valid/ready handshake to decode; branches redirect, HALT stops.
module fetch_unit #(
    parameter int                 ADDR_W   = tinycpu_pkg::ADDR_W,
    parameter int                 INSTR_W  = tinycpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [3:0]         HALT_OP  = tinycpu_pkg::OP_HALT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               ir_ready,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    import tinycpu_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               halted_q, halted_d;
    logic [15:0]        count_q, count_d;

    logic [ADDR_W-1:0]  pc;
    logic               load;
    logic               is_halt;

    assign is_halt = (imem_data[OPC_MSB:OPC_LSB] == HALT_OP);
    assign load    = (state_q == FS_RUN) && (!ir_valid_q || ir_ready) && !branch_valid;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .branch_i (branch_valid),
        .halt_i   (is_halt),
        .target_i (branch_target),
        .pc_o     (pc)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        count_d    = count_q;

        if (branch_valid) begin
            state_d    = FS_RUN;
            ir_valid_d = 1'b0;
            halted_d   = 1'b0;
        end else if (load) begin
            ir_d       = imem_data;
            ir_pc_d    = pc;
            ir_valid_d = 1'b1;
            if (is_halt) begin
                state_d  = FS_HALT;
                halted_d = 1'b1;
            end
        end else if (ir_ready) begin
            // Only reachable while halted: the parked IR drains to decode
            ir_valid_d = 1'b0;
        end

        // The handshake counts even when a branch is taken on the same edge
        if (ir_valid_q && ir_ready && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FS_RUN;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr   = pc;
    assign ir_valid    = ir_valid_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, branch, halt,
// PC wrap and reset during a stall, checked at the falling edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic        ir_valid;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_ready;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .ir_valid      (ir_valid),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_ready      (ir_ready),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ir(input string tag, input logic [15:0] e_ir, input logic [7:0] e_pc,
                            input logic [15:0] e_cnt);
        check({tag, ".valid"}, 32'(ir_valid), 32'd1);
        check({tag, ".ir"},    32'(ir), 32'(e_ir));
        check({tag, ".ir_pc"}, 32'(ir_pc), 32'(e_pc));
        check({tag, ".count"}, 32'(fetch_count), 32'(e_cnt));
    endtask

    task automatic check_bubble(input string tag, input logic [7:0] e_addr, input logic e_halt,
                                input logic [15:0] e_cnt);
        check({tag, ".valid"},  32'(ir_valid), 32'd0);
        check({tag, ".addr"},   32'(imem_addr), 32'(e_addr));
        check({tag, ".halted"}, 32'(halted), 32'(e_halt));
        check({tag, ".count"},  32'(fetch_count), 32'(e_cnt));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h1122;
        mem[1]    = 16'h3344;
        mem[2]    = 16'hDEAD;
        mem[3]    = 16'hBEEF;
        mem[4]    = 16'hF000;
        mem[8'hFF] = 16'hABCD;

        rst_n = 1'b0; ir_ready = 1'b1; branch_valid = 1'b0; branch_target = 8'h00;
        step(); step();
        check("rst.valid",  32'(ir_valid), 32'd0);
        check("rst.ir",     32'(ir), 32'd0);
        check("rst.ir_pc",  32'(ir_pc), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.count",  32'(fetch_count), 32'd0);
        check("rst.addr",   32'(imem_addr), 32'd0);

        // Sequential fetch
        rst_n = 1'b1;
        step(); check_ir("seq0", 16'h1122, 8'd0, 16'd0);
        step(); check_ir("seq1", 16'h3344, 8'd1, 16'd1);
        step(); check_ir("seq2", 16'hDEAD, 8'd2, 16'd2);

        // Stall for three cycles on DEAD
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ir("stall", 16'hDEAD, 8'd2, 16'd2);
            check("stall.addr", 32'(imem_addr), 32'd3);
        end
        ir_ready = 1'b1;
        step(); check_ir("seq3", 16'hBEEF, 8'd3, 16'd3);

        // HALT word at address 4
        step();
        check_ir("halt", 16'hF000, 8'd4, 16'd4);
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.addr",   32'(imem_addr), 32'd4);
        step(); check_bubble("halt.drain", 8'd4, 1'b1, 16'd5);
        step(); check_bubble("halt.idle1", 8'd4, 1'b1, 16'd5);
        step(); check_bubble("halt.idle2", 8'd4, 1'b1, 16'd5);
        check("halt.ir_hold", 32'(ir), 32'hF000);

        // Branch out of HALT to 0
        branch_valid = 1'b1; branch_target = 8'h00;
        step(); check_bubble("resume.bubble", 8'd0, 1'b0, 16'd5);
        branch_valid = 1'b0;
        step(); check_ir("resume0", 16'h1122, 8'd0, 16'd5);
        step(); check_ir("resume1", 16'h3344, 8'd1, 16'd6);

        // Branch to 2 while 3344 is accepted
        branch_valid = 1'b1; branch_target = 8'h02;
        step(); check_bubble("br.bubble", 8'd2, 1'b0, 16'd7);
        branch_valid = 1'b0;
        step(); check_ir("br.tgt",  16'hDEAD, 8'd2, 16'd7);
        step(); check_ir("br.next", 16'hBEEF, 8'd3, 16'd8);

        // Branch to FF and wrap to 0
        branch_valid = 1'b1; branch_target = 8'hFF;
        step(); check_bubble("wrap.bubble", 8'hFF, 1'b0, 16'd9);
        branch_valid = 1'b0;
        step(); check_ir("wrap.ff", 16'hABCD, 8'hFF, 16'd9);
        check("wrap.addr", 32'(imem_addr), 32'd0);
        step(); check_ir("wrap.00", 16'h1122, 8'd0, 16'd10);

        // Reset during a stall
        ir_ready = 1'b0;
        step(); check_ir("rstall.hold", 16'h1122, 8'd0, 16'd10);
        rst_n = 1'b0;
        step();
        check("rst2.valid",  32'(ir_valid), 32'd0);
        check("rst2.ir",     32'(ir), 32'd0);
        check("rst2.ir_pc",  32'(ir_pc), 32'd0);
        check("rst2.halted", 32'(halted), 32'd0);
        check("rst2.count",  32'(fetch_count), 32'd0);
        check("rst2.addr",   32'(imem_addr), 32'd0);
        rst_n = 1'b1; ir_ready = 1'b1;
        step(); check_ir("rst2.first", 16'h1122, 8'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
